// File: rtl/axi_protocol_checker.sv
// Passive AXI4 link monitor. It tracks outstanding bursts in order, counts
// beats against the latched AxLEN, and reports protocol violations.
module chk_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout = mem[rp];
endmodule

module axi_protocol_checker #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 8,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int ERR_CNT_WIDTH   = 8
) (
  input  logic                              axi_ACLK,
  input  logic                              axi_ARESET,
  input  logic                              axi_AWVALID,
  input  logic                              axi_AWREADY,
  input  logic [ID_WIDTH-1:0]               axi_AWID,
  input  logic [ADDR_WIDTH-1:0]             axi_AWADDR,
  input  logic [LEN_WIDTH-1:0]              axi_AWLEN,
  input  logic                              axi_WVALID,
  input  logic                              axi_WREADY,
  input  logic                              axi_WLAST,
  input  logic [DATA_WIDTH-1:0]             axi_WDATA,
  input  logic                              axi_BVALID,
  input  logic                              axi_BREADY,
  input  logic [ID_WIDTH-1:0]               axi_BID,
  input  logic                              axi_ARVALID,
  input  logic                              axi_ARREADY,
  input  logic [ID_WIDTH-1:0]               axi_ARID,
  input  logic [ADDR_WIDTH-1:0]             axi_ARADDR,
  input  logic [LEN_WIDTH-1:0]              axi_ARLEN,
  input  logic                              axi_RVALID,
  input  logic                              axi_RREADY,
  input  logic                              axi_RLAST,
  input  logic [ID_WIDTH-1:0]               axi_RID,
  input  logic                              chk_clr,
  output logic [7:0]                        err_pulse,
  output logic [7:0]                        err_flags,
  output logic [ERR_CNT_WIDTH-1:0]          err_count,
  output logic [2:0]                        first_err,
  output logic                              first_err_vld,
  output logic [$clog2(MAX_OUTSTANDING):0]  wr_outstanding,
  output logic [$clog2(MAX_OUTSTANDING):0]  rd_outstanding
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = LEN_WIDTH + 1;
  localparam int AP = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH;
  localparam int WP = DATA_WIDTH + 1;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = axi_AWVALID & axi_AWREADY;
  assign w_hs  = axi_WVALID  & axi_WREADY;
  assign b_hs  = axi_BVALID  & axi_BREADY;
  assign ar_hs = axi_ARVALID & axi_ARREADY;
  assign r_hs  = axi_RVALID  & axi_RREADY;

  logic [ID_WIDTH+LEN_WIDTH-1:0] aw_head, ar_head;
  logic [ID_WIDTH-1:0]           bp_head_id;
  logic [CW-1:0]                 aw_cnt, bp_cnt, ar_cnt;
  logic                          aw_push, w_pop, bp_push, b_pop, ar_push, r_pop;
  logic [BW-1:0]                 wbeat, rbeat;

  chk_fifo #(.W(ID_WIDTH+LEN_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_aw_fifo (
    .clk(axi_ACLK), .rst(axi_ARESET), .push(aw_push), .pop(w_pop),
    .din({axi_AWID, axi_AWLEN}), .dout(aw_head), .count(aw_cnt));

  chk_fifo #(.W(ID_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_bp_fifo (
    .clk(axi_ACLK), .rst(axi_ARESET), .push(bp_push), .pop(b_pop),
    .din(aw_head[LEN_WIDTH +: ID_WIDTH]), .dout(bp_head_id), .count(bp_cnt));

  chk_fifo #(.W(ID_WIDTH+LEN_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_ar_fifo (
    .clk(axi_ACLK), .rst(axi_ARESET), .push(ar_push), .pop(r_pop),
    .din({axi_ARID, axi_ARLEN}), .dout(ar_head), .count(ar_cnt));

  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
  assign w_pop   = w_hs & axi_WLAST & (aw_cnt != '0);
  assign b_pop   = b_hs & (bp_cnt != '0);
  assign r_pop   = r_hs & axi_RLAST & (ar_cnt != '0);
  assign aw_push = aw_hs & ((aw_cnt != CW'(MAX_OUTSTANDING)) | w_pop);
  assign bp_push = w_pop & ((bp_cnt != CW'(MAX_OUTSTANDING)) | b_pop);
  assign ar_push = ar_hs & ((ar_cnt != CW'(MAX_OUTSTANDING)) | r_pop);

  logic [CW:0] wr_sum;
  assign wr_sum         = {1'b0, aw_cnt} + {1'b0, bp_cnt};
  assign wr_outstanding = wr_sum[CW] ? '1 : wr_sum[CW-1:0];
  assign rd_outstanding = ar_cnt;

  logic [AP-1:0] aw_pay, aw_pay_q, ar_pay, ar_pay_q;
  logic [WP-1:0] w_pay, w_pay_q;
  logic          aw_stall_q, w_stall_q, ar_stall_q;
  assign aw_pay = {axi_AWID, axi_AWADDR, axi_AWLEN};
  assign ar_pay = {axi_ARID, axi_ARADDR, axi_ARLEN};
  assign w_pay  = {axi_WDATA, axi_WLAST};

  logic [5:0]    wait_cond, tmo_hit;
  logic [TW-1:0] wait_cnt [6];
  assign wait_cond = {axi_AWVALID & ~axi_AWREADY, axi_WVALID & ~axi_WREADY,
                      axi_BVALID & ~axi_BREADY, axi_ARVALID & ~axi_ARREADY,
                      axi_RVALID & ~axi_RREADY,
                      ((aw_cnt != '0) | (bp_cnt != '0) | (ar_cnt != '0)) & ~b_hs & ~r_hs};

  always_comb begin
    tmo_hit = '0;
    for (int i = 0; i < 6; i++)
      tmo_hit[i] = wait_cond[i] & (wait_cnt[i] == TW'(TIMEOUT_CYCLES - 1));
  end

  logic [7:0] viol;
  always_comb begin
    viol    = '0;
    viol[0] = aw_stall_q & (~axi_AWVALID | (aw_pay != aw_pay_q));
    viol[1] = w_stall_q  & (~axi_WVALID  | (w_pay  != w_pay_q));
    viol[2] = ar_stall_q & (~axi_ARVALID | (ar_pay != ar_pay_q));
    viol[3] = w_hs & ((aw_cnt == '0) |
              (axi_WLAST != (wbeat == {1'b0, aw_head[LEN_WIDTH-1:0]})));
    viol[4] = b_hs & ((bp_cnt == '0) | (axi_BID != bp_head_id));
    viol[5] = r_hs & ((ar_cnt == '0) |
              (axi_RLAST != (rbeat == {1'b0, ar_head[LEN_WIDTH-1:0]})) |
              (axi_RID != ar_head[LEN_WIDTH +: ID_WIDTH]));
    viol[6] = (aw_hs & ~aw_push) | (w_pop & ~bp_push) | (ar_hs & ~ar_push);
    viol[7] = |tmo_hit;
  end

  logic [2:0] first_idx;
  always_comb begin
    first_idx = '0;
    for (int i = 7; i >= 0; i--)
      if (viol[i]) first_idx = 3'(i);
  end

  always_ff @(posedge axi_ACLK or posedge axi_ARESET) begin
    if (axi_ARESET) begin
      err_pulse     <= '0;
      err_flags     <= '0;
      err_count     <= '0;
      first_err     <= '0;
      first_err_vld <= 1'b0;
      wbeat         <= '0;
      rbeat         <= '0;
      aw_stall_q    <= 1'b0;
      w_stall_q     <= 1'b0;
      ar_stall_q    <= 1'b0;
      aw_pay_q      <= '0;
      w_pay_q       <= '0;
      ar_pay_q      <= '0;
      for (int i = 0; i < 6; i++) wait_cnt[i] <= '0;
    end else begin
      err_pulse  <= viol;
      aw_stall_q <= axi_AWVALID & ~axi_AWREADY;
      w_stall_q  <= axi_WVALID  & ~axi_WREADY;
      ar_stall_q <= axi_ARVALID & ~axi_ARREADY;
      aw_pay_q   <= aw_pay;
      w_pay_q    <= w_pay;
      ar_pay_q   <= ar_pay;
      if (w_hs) wbeat <= axi_WLAST ? '0 : wbeat + BW'(1);
      if (r_hs) rbeat <= axi_RLAST ? '0 : rbeat + BW'(1);
      // Counters park at the limit so a long stall reports only once.
      for (int i = 0; i < 6; i++) begin
        if (!wait_cond[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != TW'(TIMEOUT_CYCLES))
          wait_cnt[i] <= wait_cnt[i] + TW'(1);
      end
      if (chk_clr) begin
        err_flags     <= '0;
        err_count     <= '0;
        first_err     <= '0;
        first_err_vld <= 1'b0;
      end else begin
        err_flags <= err_flags | viol;
        if ((viol != '0) && (err_count != '1))
          err_count <= err_count + ERR_CNT_WIDTH'(1);
        if (!first_err_vld && (viol != '0)) begin
          first_err     <= first_idx;
          first_err_vld <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_protocol_checker.sv
// Bench for axi_protocol_checker: directed vector table, hand sequences, and
// random traffic checked against a queue-based reference model.
module tb_axi_protocol_checker;
  localparam int AW = 16, DW = 32, LW = 8, IW = 4, MO = 4, TO = 16, EW = 8;
  localparam int OW = $clog2(MO) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          awv, awr, wv, wr, wl, bv, br, arv, arr, rv, rr, rl, clr;
  logic [IW-1:0] awid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [LW-1:0] awlen, arlen;
  logic [DW-1:0] wdata;
  logic [7:0]    err_pulse, err_flags;
  logic [EW-1:0] err_count;
  logic [2:0]    first_err;
  logic          first_err_vld;
  logic [OW-1:0] wr_out, rd_out;

  axi_protocol_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ID_WIDTH(IW),
    .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO), .ERR_CNT_WIDTH(EW)) dut (
    .axi_ACLK(clk), .axi_ARESET(rst),
    .axi_AWVALID(awv), .axi_AWREADY(awr), .axi_AWID(awid), .axi_AWADDR(awaddr), .axi_AWLEN(awlen),
    .axi_WVALID(wv), .axi_WREADY(wr), .axi_WLAST(wl), .axi_WDATA(wdata),
    .axi_BVALID(bv), .axi_BREADY(br), .axi_BID(bid),
    .axi_ARVALID(arv), .axi_ARREADY(arr), .axi_ARID(arid), .axi_ARADDR(araddr), .axi_ARLEN(arlen),
    .axi_RVALID(rv), .axi_RREADY(rr), .axi_RLAST(rl), .axi_RID(rid),
    .chk_clr(clr), .err_pulse(err_pulse), .err_flags(err_flags), .err_count(err_count),
    .first_err(first_err), .first_err_vld(first_err_vld),
    .wr_outstanding(wr_out), .rd_outstanding(rd_out));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int id; int len;} burst_t;
  burst_t aw_q[$], ar_q[$];
  int     bp_q[$];
  int     wbeat, rbeat;
  int     wait_n[6];
  bit     aw_st, w_st, ar_st;
  logic [IW+AW+LW-1:0] aw_pv, ar_pv;
  logic [DW:0]         w_pv;
  logic [7:0] m_pulse, m_flags;
  int     m_cnt, m_fe;
  bit     m_fv;

  function automatic void model_reset();
    aw_q.delete(); ar_q.delete(); bp_q.delete();
    wbeat = 0; rbeat = 0;
    for (int i = 0; i < 6; i++) wait_n[i] = 0;
    aw_st = 0; w_st = 0; ar_st = 0; aw_pv = '0; ar_pv = '0; w_pv = '0;
    m_pulse = '0; m_flags = '0; m_cnt = 0; m_fe = 0; m_fv = 0;
  endfunction

  function automatic void model_step();
    logic [7:0] v;
    bit awh, wh, bh, arh, rh, w_pop, b_pop, r_pop, aw_ok, bp_ok, ar_ok;
    int aw_n, bp_n, ar_n;
    bit [5:0] c;
    burst_t hd, nb;
    v = '0;
    awh = awv && awr; wh = wv && wr; bh = bv && br; arh = arv && arr; rh = rv && rr;
    aw_n = aw_q.size(); bp_n = bp_q.size(); ar_n = ar_q.size();
    if (aw_st && (!awv || {awid, awaddr, awlen} != aw_pv)) v[0] = 1;
    if (w_st && (!wv || {wdata, wl} != w_pv)) v[1] = 1;
    if (ar_st && (!arv || {arid, araddr, arlen} != ar_pv)) v[2] = 1;
    w_pop = 0; b_pop = 0; r_pop = 0;
    if (wh) begin
      if (aw_n == 0 || (wl != (wbeat == aw_q[0].len))) v[3] = 1;
      w_pop = wl && aw_n > 0;
      wbeat = wl ? 0 : wbeat + 1;
    end
    if (bh) begin
      if (bp_n == 0 || int'(bid) != bp_q[0]) v[4] = 1;
      b_pop = bp_n > 0;
    end
    if (rh) begin
      if (ar_n == 0 || (rl != (rbeat == ar_q[0].len)) || int'(rid) != ar_q[0].id) v[5] = 1;
      r_pop = rl && ar_n > 0;
      rbeat = rl ? 0 : rbeat + 1;
    end
    aw_ok = awh && (aw_n < MO || w_pop);
    bp_ok = w_pop && (bp_n < MO || b_pop);
    ar_ok = arh && (ar_n < MO || r_pop);
    if ((awh && !aw_ok) || (w_pop && !bp_ok) || (arh && !ar_ok)) v[6] = 1;
    if (b_pop) void'(bp_q.pop_front());
    if (w_pop) begin
      hd = aw_q.pop_front();
      if (bp_ok) bp_q.push_back(hd.id);
    end
    if (aw_ok) begin nb.id = int'(awid); nb.len = int'(awlen); aw_q.push_back(nb); end
    if (r_pop) void'(ar_q.pop_front());
    if (ar_ok) begin nb.id = int'(arid); nb.len = int'(arlen); ar_q.push_back(nb); end
    c = {awv && !awr, wv && !wr, bv && !br, arv && !arr, rv && !rr,
         (aw_n + bp_n + ar_n > 0) && !bh && !rh};
    for (int i = 0; i < 6; i++) begin
      if (!c[i]) wait_n[i] = 0;
      else if (wait_n[i] < TO) begin
        wait_n[i]++;
        if (wait_n[i] == TO) v[7] = 1;
      end
    end
    aw_st = awv && !awr; w_st = wv && !wr; ar_st = arv && !arr;
    aw_pv = {awid, awaddr, awlen}; w_pv = {wdata, wl}; ar_pv = {arid, araddr, arlen};
    m_pulse = v;
    if (clr) begin
      m_flags = '0; m_cnt = 0; m_fv = 0; m_fe = 0;
    end else begin
      m_flags |= v;
      if (v != 0 && m_cnt < 255) m_cnt++;
      if (!m_fv && v != 0) begin
        m_fv = 1;
        for (int i = 7; i >= 0; i--) if (v[i]) m_fe = i;
      end
    end
  endfunction

  task automatic check_model();
    int wsum;
    wsum = aw_q.size() + bp_q.size();
    if (wsum > 2 ** OW - 1) wsum = 2 ** OW - 1;
    check("m_err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("m_err_flags", 32'(err_flags), 32'(m_flags));
    check("m_err_count", 32'(err_count), 32'(m_cnt));
    check("m_first_err_vld", 32'(first_err_vld), 32'(m_fv));
    check("m_first_err", 32'(first_err), 32'(m_fe));
    check("m_wr_outstanding", 32'(wr_out), 32'(wsum));
    check("m_rd_outstanding", 32'(rd_out), 32'(ar_q.size()));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive_idle();
    awv = 0; awr = 0; awid = '0; awaddr = '0; awlen = '0;
    wv = 0; wr = 0; wl = 0; wdata = '0; bv = 0; br = 0; bid = '0;
    arv = 0; arr = 0; arid = '0; araddr = '0; arlen = '0;
    rv = 0; rr = 0; rl = 0; rid = '0; clr = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic awv; int awid; int awlen; logic wv; logic wl; logic bv; int bid;
    logic arv; int arid; int arlen; logic rv; logic rl; int rid; logic clr;
    int pulse; int wr_o; int rd_o; int flags; int cnt; int fe;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t nop(logic c);
    vec_t t = '{default: 0}; t.clr = c; return t;
  endfunction
  function automatic vec_t v_aw(int id, int len);
    vec_t t = nop(0); t.awv = 1; t.awid = id; t.awlen = len; return t;
  endfunction
  function automatic vec_t v_w(logic last);
    vec_t t = nop(0); t.wv = 1; t.wl = last; return t;
  endfunction
  function automatic vec_t v_b(int id);
    vec_t t = nop(0); t.bv = 1; t.bid = id; return t;
  endfunction
  function automatic vec_t v_ar(int id, int len);
    vec_t t = nop(0); t.arv = 1; t.arid = id; t.arlen = len; return t;
  endfunction
  function automatic vec_t v_r(int id, logic last);
    vec_t t = nop(0); t.rv = 1; t.rid = id; t.rl = last; return t;
  endfunction
  function automatic void add(vec_t t, int p, int w, int r, int f, int c, int fe);
    t.pulse = p; t.wr_o = w; t.rd_o = r; t.flags = f; t.cnt = c; t.fe = fe;
    tbl.push_back(t);
  endfunction

  initial begin
    int n0, n7, t7, rp;
    drive_idle();
    model_reset();
    repeat (3) step();
    rst = 0;
    step();
    check("reset_pulse", 32'(err_pulse), 0);
    check("reset_flags", 32'(err_flags), 0);
    check("reset_count", 32'(err_count), 0);
    check("reset_first", 32'({first_err_vld, first_err}), 0);
    check("reset_outst", 32'({wr_out, rd_out}), 0);

    add(v_aw(3, 3), 'h00, 1, 0, 'h00, 0, 0);
    add(v_w(0),     'h00, 1, 0, 'h00, 0, 0);
    add(v_w(0),     'h00, 1, 0, 'h00, 0, 0);
    add(v_w(0),     'h00, 1, 0, 'h00, 0, 0);
    add(v_w(1),     'h00, 1, 0, 'h00, 0, 0);
    add(v_b(3),     'h00, 0, 0, 'h00, 0, 0);
    add(nop(0),     'h00, 0, 0, 'h00, 0, 0);
    add(v_aw(0, 1), 'h00, 1, 0, 'h00, 0, 0);
    add(v_w(1),     'h08, 1, 0, 'h08, 1, 'hB);
    add(v_b(0),     'h00, 0, 0, 'h08, 1, 'hB);
    add(v_ar(1, 0), 'h00, 0, 1, 'h08, 1, 'hB);
    add(v_ar(2, 0), 'h00, 0, 2, 'h08, 1, 'hB);
    add(v_r(2, 1),  'h20, 0, 1, 'h28, 2, 'hB);
    add(v_r(2, 1),  'h00, 0, 0, 'h28, 2, 'hB);
    add(v_ar(0, 0), 'h00, 0, 1, 'h28, 2, 'hB);
    add(v_ar(1, 0), 'h00, 0, 2, 'h28, 2, 'hB);
    add(v_ar(2, 0), 'h00, 0, 3, 'h28, 2, 'hB);
    add(v_ar(3, 0), 'h00, 0, 4, 'h28, 2, 'hB);
    add(v_ar(4, 0), 'h40, 0, 4, 'h68, 3, 'hB);
    add(nop(1),     'h00, 0, 4, 'h00, 0, 0);
    add(v_r(0, 1),  'h00, 0, 3, 'h00, 0, 0);
    add(v_r(1, 1),  'h00, 0, 2, 'h00, 0, 0);
    add(v_r(2, 1),  'h00, 0, 1, 'h00, 0, 0);
    add(v_r(3, 1),  'h00, 0, 0, 'h00, 0, 0);

    foreach (tbl[k]) begin
      drive_idle();
      awv = tbl[k].awv; awr = tbl[k].awv; awid = IW'(tbl[k].awid); awlen = LW'(tbl[k].awlen);
      awaddr = AW'('h100);
      wv = tbl[k].wv; wr = tbl[k].wv; wl = tbl[k].wl;
      bv = tbl[k].bv; br = tbl[k].bv; bid = IW'(tbl[k].bid);
      arv = tbl[k].arv; arr = tbl[k].arv; arid = IW'(tbl[k].arid); arlen = LW'(tbl[k].arlen);
      araddr = AW'('h200);
      rv = tbl[k].rv; rr = tbl[k].rv; rl = tbl[k].rl; rid = IW'(tbl[k].rid);
      clr = tbl[k].clr;
      step();
      check($sformatf("tbl%0d_pulse", k), 32'(err_pulse), tbl[k].pulse);
      check($sformatf("tbl%0d_wr", k), 32'(wr_out), tbl[k].wr_o);
      check($sformatf("tbl%0d_rd", k), 32'(rd_out), tbl[k].rd_o);
      check($sformatf("tbl%0d_flags", k), 32'(err_flags), tbl[k].flags);
      check($sformatf("tbl%0d_cnt", k), 32'(err_count), tbl[k].cnt);
      check($sformatf("tbl%0d_first", k), 32'({first_err_vld, first_err}), tbl[k].fe);
    end

    // AW stall with an address change, then held until the wait timer expires
    drive_idle();
    awv = 1; awid = 5; awlen = 2; awaddr = AW'('h10);
    n0 = 0; n7 = 0; t7 = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i >= 2) awaddr = AW'('h14);
      step();
      if (err_pulse[0]) n0++;
      if (err_pulse[7]) begin n7++; t7 = i; end
    end
    check("aw_stable_pulses", 32'(n0), 1);
    check("timeout_pulses", 32'(n7), 1);
    check("timeout_cycle", 32'(t7), 16);
    drive_idle();
    step();
    clr = 1;
    step();

    // error counter saturation and clear
    drive_idle();
    wv = 1; wr = 1;
    for (int i = 1; i <= 260; i++) begin
      step();
      if (i == 255) check("sat_count_255", 32'(err_count), 255);
    end
    check("sat_count_hold", 32'(err_count), 255);
    check("sat_flags", 32'(err_flags), 'h08);
    check("sat_first", 32'({first_err_vld, first_err}), 'hB);
    drive_idle();
    clr = 1;
    step();
    check("clr_flags", 32'(err_flags), 0);
    check("clr_count", 32'(err_count), 0);
    check("clr_first_vld", 32'(first_err_vld), 0);

    // reset in the middle of a write burst discards tracking
    drive_idle();
    awv = 1; awr = 1; awid = 1; awlen = 1;
    step();
    drive_idle();
    wv = 1; wr = 1;
    step();
    check("midburst_wr", 32'(wr_out), 1);
    drive_idle();
    rst = 1;
    step();
    check("rst_wr", 32'(wr_out), 0);
    rst = 0;
    wv = 1; wr = 1; wl = 1; rv = 1; rr = 1; rl = 1;
    step();
    check("post_rst_pulse", 32'(err_pulse), 'h28);
    drive_idle();
    step();

    // random traffic against the reference model
    rp = 60;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 100 == 0) rp = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(30, 90);
      if (!(awv && !awr) || $urandom_range(0, 9) == 0) begin
        awv = ($urandom_range(0, 2) == 0); awid = IW'($urandom_range(0, 3));
        awlen = LW'($urandom_range(0, 3)); awaddr = AW'($urandom);
      end
      awr = ($urandom_range(0, 99) < rp);
      if (!(wv && !wr) || $urandom_range(0, 9) == 0) begin
        wv = ($urandom_range(0, 1) == 0); wdata = $urandom;
        wl = (aw_q.size() > 0 && $urandom_range(0, 9) < 8) ? (wbeat == aw_q[0].len)
                                                          : ($urandom_range(0, 3) == 0);
      end
      wr = ($urandom_range(0, 99) < rp);
      bv = ($urandom_range(0, 2) == 0);
      bid = (bp_q.size() > 0 && $urandom_range(0, 9) < 8) ? IW'(bp_q[0]) : IW'($urandom_range(0, 3));
      br = ($urandom_range(0, 99) < rp);
      if (!(arv && !arr) || $urandom_range(0, 9) == 0) begin
        arv = ($urandom_range(0, 2) == 0); arid = IW'($urandom_range(0, 3));
        arlen = LW'($urandom_range(0, 3)); araddr = AW'($urandom);
      end
      arr = ($urandom_range(0, 99) < rp);
      rv = ($urandom_range(0, 1) == 0);
      if (ar_q.size() > 0 && $urandom_range(0, 9) < 8) begin
        rid = IW'(ar_q[0].id); rl = (rbeat == ar_q[0].len);
      end else begin
        rid = IW'($urandom_range(0, 3)); rl = ($urandom_range(0, 3) == 0);
      end
      rr = ($urandom_range(0, 99) < rp);
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 799) == 0) rst = 1;
      step();
      rst = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi_protocol_checker.md
Name: axi_protocol_checker

Overview:
- Synthesisable, parametrised AXI4 protocol monitor. Sits passively on one master/slave link, in RTL or on silicon.
- Tracks multiple outstanding transactions per direction in in-order FIFOs and counts beats against latched AxLEN.
- Detects handshake-stability, LAST-position, ID-ordering, overflow and timeout violations.
- Reports violations through sticky flags, per-cycle pulses, a saturating error count and a first-error capture.

Parameters:
- ADDR_WIDTH, 16, address width.
- DATA_WIDTH, 32, data width.
- LEN_WIDTH, 8, AxLEN width.
- ID_WIDTH, 4, AxID/xID width.
- MAX_OUTSTANDING, 4, depth of the AW, B-pending and AR tracking FIFOs; power of 2, at least 2.
- TIMEOUT_CYCLES, 16, maximum wait cycles before a timeout is flagged; at least 2.
- ERR_CNT_WIDTH, 8, width of err_count.

Ports:
- axi_ACLK, in, 1, clock.
- axi_ARESET, in, 1, asynchronous active-high reset.
- axi_AWVALID / axi_AWREADY, in, 1 each.
- axi_AWID / axi_AWADDR / axi_AWLEN, in, ID_WIDTH / ADDR_WIDTH / LEN_WIDTH.
- axi_WVALID / axi_WREADY / axi_WLAST, in, 1 each.
- axi_WDATA, in, DATA_WIDTH.
- axi_BVALID / axi_BREADY, in, 1 each.
- axi_BID, in, ID_WIDTH.
- axi_ARVALID / axi_ARREADY, in, 1 each.
- axi_ARID / axi_ARADDR / axi_ARLEN, in, ID_WIDTH / ADDR_WIDTH / LEN_WIDTH.
- axi_RVALID / axi_RREADY / axi_RLAST, in, 1 each.
- axi_RID, in, ID_WIDTH.
- chk_clr, in, 1, synchronous clear of err_flags, err_count and first_err.
- err_pulse, out, 8, violations detected this cycle; registered.
- err_flags, out, 8, sticky OR of err_pulse.
- err_count, out, ERR_CNT_WIDTH, number of cycles with any err_pulse bit set; saturates at all-ones.
- first_err, out, 3, index of the lowest set bit of the first nonzero err_pulse since reset or clear.
- first_err_vld, out, 1, first_err is valid.
- wr_outstanding, out, $clog2(MAX_OUTSTANDING)+1, AW-FIFO occupancy plus B-pending occupancy.
- rd_outstanding, out, $clog2(MAX_OUTSTANDING)+1, AR-FIFO occupancy.

Behaviour:
- Reset (async): all outputs 0, all FIFOs empty, beat counters 0, wait counters 0.
- Violations are evaluated from sampled inputs at edge N; err_pulse is visible after edge N and lasts one cycle. Latency is 1.
- Bit 0 AW_STABLE: AWVALID & !AWREADY at edge N-1 and, at edge N, AWVALID dropped or {AWID,AWADDR,AWLEN} changed.
- Bit 1 W_STABLE: same rule for W over {WDATA,WLAST}.
- Bit 2 AR_STABLE: same rule for AR over {ARID,ARADDR,ARLEN}.
- Write tracking:
  - AW handshake pushes {AWID,AWLEN}.
  - Each W handshake increments wbeat.
  - The expected last beat is the one where wbeat == head.len; compare width LEN_WIDTH+1, so no wrap at AWLEN=255.
  - On WLAST handshake, pop the AW head, push its ID into B-pending, and reset wbeat to 0.
- Bit 3 WLAST_ERR:
  - WLAST mismatches the expected position, or
  - a W handshake occurs while the AW FIFO is empty. Write data before address is illegal in this system.
  - On a mismatch the beat is still treated per WLAST (pop if WLAST=1), so tracking resynchronises.
- An AW handshake and a WLAST pop in the same cycle: both take effect; occupancy is unchanged.
- Bit 4 B_ERR: B handshake with B-pending empty, or BID != head ID. The head is popped whenever the FIFO is non-empty.
- Read tracking: AR handshake pushes {ARID,ARLEN}. Each R handshake increments rbeat and is checked against the head. RLAST handshake pops the head and resets rbeat.
- Bit 5 R_ERR:
  - RLAST position mismatch, R with AR FIFO empty, or RID != head ID.
  - All sub-cases set the same bit.
- Bit 6 OVERFLOW: a push into a full FIFO. The push is dropped and the FIFO contents are unchanged.
- Bit 7 TIMEOUT:
  - Each channel has a wait counter: xVALID & !xREADY increments it, otherwise it clears.
  - A response counter increments while wr_outstanding or rd_outstanding is nonzero with no B/R handshake that cycle.
  - The bit is flagged when any counter reaches TIMEOUT_CYCLES. The counter then holds at that value (no repeat pulse) until its clear condition.
- Multiple violations in one cycle set multiple err_pulse bits. first_err takes the lowest index.
- chk_clr and a new violation in the same cycle: the clear wins for flags, count and first_err; err_pulse still shows the violation.
- Reset mid-burst discards all tracking. Beats arriving after reset with empty FIFOs flag bits 3 and 5.

Test Plan:
- AW id=3 len=3, then 4 W beats with WLAST on beat 4, then B id=3 -> err_flags=0, wr_outstanding goes 1 then 0.
- AW len=1, WLAST asserted on beat 1 -> err_pulse=0x08 one cycle later; first_err=3; err_count=1.
- Two ARs id=1 then id=2 (len 0 each), R returns id=2 first -> err_pulse bit 5 set.
- AWVALID high, AWREADY low, AWADDR changes 0x10->0x14 -> bit 0 set; with TIMEOUT_CYCLES=16 and AWREADY held low for 16 cycles -> bit 7 pulses exactly once.
- MAX_OUTSTANDING=4: 5 ARs with no R -> bit 6 set on the 5th AR; rd_outstanding=4.
- 255 consecutive error cycles with ERR_CNT_WIDTH=8 -> err_count=255 and holds; chk_clr -> flags, count and first_err_vld return to 0.
